serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 118 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a-b LSB-first, one full-subtractor step per cycle.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output (ovf).
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             br
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q, busy_q, done_q, br_q;
    logic             ai, bi, bit_d, bout_d, last_bit;
    logic [WIDTH-1:0] res_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs; result bits enter from the MSB side.
    assign ai       = a_sh_q[0];
    assign bi       = b_sh_q[0];
    assign bit_d    = ai ^ bi ^ borrow_q;
    assign bout_d   = (~ai & bi) | (~(ai ^ bi) & borrow_q);
    assign res_d    = {bit_d, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
`ifdef SERIAL_SUB_OVF_EN
    // On the last step ai/bi are the operand sign bits and bit_d is the result sign.
    assign ovf_d    = (ai ^ bi) & (bit_d ^ ai);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            br_q     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    borrow_q <= bout_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // Visible outputs change only here, so they stay stable between results.
                        diff_q  <= res_d;
                        br_q    <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign br   = br_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): scoreboard of expected results
// checked whenever done pulses, plus timing, reset and back-to-back checks.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b, diff;
    logic         busy, done, br;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   pass_cnt = 0;
    int   total    = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .br    (br)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        e.d  = ea - eb;
        e.br = (ea < eb);
        e.ov = (ea[W-1] != eb[W-1]) && (e.d[W-1] != ea[W-1]);
        sb.push_back(e);
    endtask

    // Drive one request; returns just after the accepting edge with start low.
    task automatic go(input logic [W-1:0] va, input logic [W-1:0] vb);
        a = va; b = vb; start = 1'b1;
        push_exp(va, vb);
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done();
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 3 * W && done_cnt == n0; i++) tick();
        chk("done_seen", 32'(done_cnt != n0), 1);
        tick();
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            done_cyc.push_back(cyc);
            chk("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_diff", 32'(diff), 32'(e.d));
                chk("sb_br", 32'(br), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                chk("sb_ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_len, done_len, n0, gap;

        // Reset with start held high: nothing may be accepted.
        rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_br", 32'(br), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0; start = 1'b0;
        tick();
        chk("idle_after_rst", 32'(busy), 0);

        // Basic timing: 5-3.
        go(8'h05, 8'h03);
        chk("busy_at_accept", 32'(busy), 1);
        busy_len = 1; done_len = 0;
        for (int i = 1; i <= W + 1; i++) begin
            tick();
            busy_len += int'(busy);
            done_len += int'(done);
            if (i == W) chk("done_at_W", 32'(done), 1);
        end
        chk("busy_len", 32'(busy_len), W + 1);
        chk("done_len", 32'(done_len), 1);
        chk("diff_5m3", 32'(diff), 32'h02);
        chk("br_5m3", 32'(br), 0);

        go(8'h00, 8'h00); wait_done();
        chk("diff_0m0", 32'(diff), 32'h00);
        chk("br_0m0", 32'(br), 0);
        go(8'h03, 8'h05); wait_done();
        chk("diff_3m5", 32'(diff), 32'hFE);
        chk("br_3m5", 32'(br), 1);
        repeat (4) tick();
        chk("hold_diff", 32'(diff), 32'hFE);
        chk("hold_br", 32'(br), 1);

        // start held high through a whole operation: one result only.
        n0 = done_cnt;
        a = 8'hFF; b = 8'h01; start = 1'b1;
        push_exp(8'hFF, 8'h01);
        tick();
        a = W'($urandom); b = W'($urandom);
        repeat (W) tick();
        chk("ign_done", 32'(done), 1);
        tick();
        chk("ign_idle", 32'(busy), 0);
        start = 1'b0;
        repeat (3) tick();
        chk("ign_one_result", 32'(done_cnt - n0), 1);
        chk("ign_diff", 32'(diff), 32'hFE);
        chk("ign_br", 32'(br), 0);

        // Reset during bit 4 aborts the operation.
        go(8'h80, 8'h01);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_br", 32'(br), 0);
        sb.delete();
        n0 = done_cnt;
        repeat (W + 3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("abort_no_done", 32'(done_cnt - n0), 0);
        go(8'h10, 8'h01); wait_done();
        chk("diff_10m1", 32'(diff), 32'h0F);
        chk("br_10m1", 32'(br), 0);

        // Back-to-back: re-assert start in the first IDLE cycle.
        go(8'h40, 8'h20);
        repeat (W) tick();
        chk("b2b_done1", 32'(done), 1);
        a = 8'h33; b = 8'h44; start = 1'b1;
        push_exp(8'h33, 8'h44);
        tick();
        tick();
        start = 1'b0;
        wait_done();
        gap = done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2];
        chk("b2b_gap", 32'(gap), W + 2);
        chk("diff_b2b", 32'(diff), 32'hEF);
        chk("br_b2b", 32'(br), 1);

`ifdef SERIAL_SUB_OVF_EN
        go(8'h80, 8'h01); wait_done();
        chk("ovf_diff_a", 32'(diff), 32'h7F);
        chk("ovf_br_a", 32'(br), 0);
        chk("ovf_a", 32'(ovf), 1);
        go(8'h01, 8'h02); wait_done();
        chk("ovf_diff_b", 32'(diff), 32'hFF);
        chk("ovf_br_b", 32'(br), 1);
        chk("ovf_b", 32'(ovf), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            go(W'($urandom), W'($urandom));
            wait_done();
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
